seven_segment_scroller: RTL and testbench

Message source for the DE10-Lite 6-digit display. Accepts a short message of 3-bit character codes over a valid/ready write port and stores it in an internal buffer. On command it scrolls the message right-to-left across the digits at a prescaled tick rate. Its per-digit code outputs feed one single-digit character decoder per display digit (code 000 → F, 001 → E, 011 → r); its blank mask gates those digits off.

---
 rtl/seven_segment_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/seven_segment_scroller.sv | 174 +++++++++++++++++
 tb/tb_seven_segment_scroller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment message scroller.
package seven_segment_pkg;

    // Character code width expected by the single-digit decoder.
    localparam int DEFAULT_CODE_W = 3;

    // Decoder character codes.
    localparam logic [DEFAULT_CODE_W-1:0] CODE_F = 3'b000;
    localparam logic [DEFAULT_CODE_W-1:0] CODE_E = 3'b001;
    localparam logic [DEFAULT_CODE_W-1:0] CODE_R = 3'b011;

    // Scroller control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_LOADED    = 2'd2,
        ST_SCROLLING = 2'd3
    } scroll_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV cycles, with a
// synchronous clear that restarts the count at zero.
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap; clear wins over counting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seven_segment_scroller.sv
// Message buffer and right-to-left scroller driving a row of single-digit
// character decoders. All outputs are registered from next-state values so
// the display reflects a new position one cycle after the deciding edge.
module seven_segment_scroller
    import seven_segment_pkg::*;
#(
    parameter int CODE_W   = DEFAULT_CODE_W,
    parameter int DIGITS   = 6,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [CODE_W-1:0]        wr_code_i,
    input  logic                     wr_last_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic [DIGITS*CODE_W-1:0] digits_o,
    output logic [DIGITS-1:0]        blank_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int POS_W = $clog2(DEPTH + DIGITS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    scroll_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DEPTH-1:0][CODE_W-1:0] msg_q;

    logic              wr_hs;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              tick;
    logic              presc_clr;
    logic              done_d;
    logic [POS_W:0]    pos_max;
    logic [POS_W:0]    rel;
    logic [DIGITS*CODE_W-1:0] win_digits;
    logic [DIGITS-1:0]        win_blank;

    // Prescaler only runs while scrolling; any (re)start holds it at zero.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (presc_clr),
        .tick_o  (tick)
    );

    assign wr_hs   = wr_valid_i & wr_ready_o;
    // Last character reaches the leftmost digit at len + DIGITS - 2.
    assign pos_max = (POS_W+1)'(len_q) + (POS_W+1)'(DIGITS - 2);

    // Control: loading, start/stop/restart priority and position stepping.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        pos_d     = pos_q;
        wr_en     = 1'b0;
        wr_idx    = '0;
        done_d    = 1'b0;
        presc_clr = 1'b1;
        case (state_q)
            ST_IDLE, ST_LOADED: begin
                if (wr_hs) begin
                    // First beat of a new message replaces any old one.
                    wr_en   = 1'b1;
                    count_d = CNT_W'(1);
                    if (wr_last_i || (DEPTH == 1)) begin
                        len_d   = CNT_W'(1);
                        state_d = ST_LOADED;
                    end else begin
                        state_d = ST_LOADING;
                    end
                end else if (start_i && (state_q == ST_LOADED)) begin
                    pos_d   = '0;
                    state_d = ST_SCROLLING;
                end
            end
            ST_LOADING: begin
                if (wr_hs) begin
                    wr_en   = 1'b1;
                    wr_idx  = IDX_W'(count_q);
                    count_d = count_q + 1'b1;
                    // A full buffer closes the message even without last.
                    if (wr_last_i || (count_q == CNT_W'(DEPTH - 1))) begin
                        len_d   = count_q + 1'b1;
                        state_d = ST_LOADED;
                    end
                end
            end
            ST_SCROLLING: begin
                presc_clr = 1'b0;
                if (stop_i) begin
                    presc_clr = 1'b1;
                    state_d   = ST_LOADED;
                end else if (start_i) begin
                    presc_clr = 1'b1;
                    pos_d     = '0;
                end else if (tick) begin
                    if ((POS_W+1)'(pos_q) < pos_max) begin
                        pos_d = pos_q + 1'b1;
                    end else if (loop_i) begin
                        pos_d = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_LOADED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window: digit k shows character pos-k when it lies inside the message.
    always_comb begin
        win_digits = '0;
        win_blank  = '1;
        rel        = '0;
        for (int k = 0; k < DIGITS; k++) begin
            rel = (POS_W+1)'(pos_d) - (POS_W+1)'(k);
            if (((POS_W+1)'(pos_d) >= (POS_W+1)'(k)) && (rel < (POS_W+1)'(len_q))) begin
                win_digits[k*CODE_W +: CODE_W] = msg_q[rel[IDX_W-1:0]];
                win_blank[k]                   = 1'b0;
            end
        end
    end

    // Message storage; contents are don't-care until a message is loaded.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            msg_q[wr_idx] <= wr_code_i;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            pos_q      <= '0;
            wr_ready_o <= 1'b1;
            digits_o   <= '0;
            blank_o    <= '1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            wr_ready_o <= (state_d != ST_SCROLLING);
            busy_o     <= (state_d == ST_SCROLLING);
            done_o     <= done_d;
            if (state_d == ST_SCROLLING) begin
                digits_o <= win_digits;
                blank_o  <= win_blank;
            end else begin
                blank_o  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scroller.sv
// Directed bench for seven_segment_scroller with a 4-cycle scroll step.
module tb_seven_segment_scroller;

    localparam int CODE_W   = 3;
    localparam int DIGITS   = 6;
    localparam int DEPTH    = 16;
    localparam int TICK_DIV = 4;

    localparam logic [2:0] C_F = 3'b000;
    localparam logic [2:0] C_E = 3'b001;
    localparam logic [2:0] C_R = 3'b011;

    logic clk_i      = 1'b0;
    logic rst_ni     = 1'b1;
    logic wr_valid_i = 1'b0;
    logic wr_last_i  = 1'b0;
    logic start_i    = 1'b0;
    logic stop_i     = 1'b0;
    logic loop_i     = 1'b0;
    logic [CODE_W-1:0]        wr_code_i = '0;
    logic                     wr_ready_o;
    logic [DIGITS*CODE_W-1:0] digits_o;
    logic [DIGITS-1:0]        blank_o;
    logic                     busy_o;
    logic                     done_o;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int done_base;

    seven_segment_scroller #(
        .CODE_W   (CODE_W),
        .DIGITS   (DIGITS),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_code_i  (wr_code_i),
        .wr_last_i  (wr_last_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .loop_i     (loop_i),
        .digits_o   (digits_o),
        .blank_o    (blank_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_o) n_done++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] dig(input int k);
        return digits_o[k*CODE_W +: CODE_W];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wr_beat(input logic [2:0] code, input logic last);
        wr_valid_i = 1'b1;
        wr_code_i  = code;
        wr_last_i  = last;
        cyc(1);
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
    endtask

    task automatic go();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic halt();
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] c;
        // reset
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ready", wr_ready_o, 1);
        chk("rst_digits", digits_o, 0);
        chk("rst_blank", blank_o, 6'h3f);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);
        chk("idle_ready", wr_ready_o, 1);

        // basic pass: F E r
        wr_beat(C_F, 0); wr_beat(C_E, 0); wr_beat(C_R, 1);
        go();
        chk("p0_busy", busy_o, 1);
        chk("p0_blank", blank_o, 6'h3e);
        chk("p0_d0", dig(0), C_F);
        cyc(4);
        chk("p1_blank", blank_o, 6'h3c);
        chk("p1_d1", dig(1), C_F);
        chk("p1_d0", dig(0), C_E);
        cyc(4);
        chk("p2_blank", blank_o, 6'h38);
        chk("p2_d2", dig(2), C_F);
        chk("p2_d1", dig(1), C_E);
        chk("p2_d0", dig(0), C_R);
        cyc(20);
        chk("p7_blank", blank_o, 6'h1f);
        chk("p7_d5", dig(5), C_R);
        chk("p7_busy", busy_o, 1);
        cyc(3);
        chk("p7_nodone", done_o, 0);
        cyc(1);
        chk("fin_done", done_o, 1);
        chk("fin_busy", busy_o, 0);
        chk("fin_blank", blank_o, 6'h3f);
        chk("fin_hold", dig(5), C_R);
        cyc(1);
        chk("fin_pulse", done_o, 0);

        // single character, looping
        done_base = n_done;
        loop_i = 1'b1;
        wr_beat(C_E, 1);
        go();
        chk("l0_d0", dig(0), C_E);
        chk("l0_blank", blank_o, 6'h3e);
        cyc(20);
        chk("l5_blank", blank_o, 6'h1f);
        chk("l5_d5", dig(5), C_E);
        cyc(4);
        chk("lwrap_d0", dig(0), C_E);
        chk("lwrap_blank", blank_o, 6'h3e);
        chk("lwrap_busy", busy_o, 1);

        // stop + start together
        cyc(2);
        stop_i = 1'b1; start_i = 1'b1;
        cyc(1);
        stop_i = 1'b0; start_i = 1'b0;
        chk("ss_busy", busy_o, 0);
        chk("ss_blank", blank_o, 6'h3f);
        chk("ss_ready", wr_ready_o, 1);
        cyc(2);
        chk("ss_stay", busy_o, 0);
        chk("ss_nodone", n_done - done_base, 0);

        // start with write in LOADED: write wins, start in LOADING ignored
        wr_valid_i = 1'b1; wr_code_i = C_R; wr_last_i = 1'b0; start_i = 1'b1;
        cyc(1);
        wr_valid_i = 1'b0; start_i = 1'b0;
        chk("sw_busy", busy_o, 0);
        go();
        cyc(1);
        chk("ld_start_ign", busy_o, 0);
        wr_beat(C_F, 1);
        loop_i = 1'b0;
        go();
        chk("sw0_d0", dig(0), C_R);
        chk("sw0_blank", blank_o, 6'h3e);
        cyc(4);
        chk("sw1_d1", dig(1), C_R);
        chk("sw1_d0", dig(0), C_F);

        // write held during scroll
        wr_valid_i = 1'b1; wr_code_i = C_E; wr_last_i = 1'b1;
        repeat (23) begin
            cyc(1);
            chk("scr_ready", wr_ready_o, 0);
        end
        cyc(1);
        chk("scr_done", done_o, 1);
        chk("scr_ready_up", wr_ready_o, 1);
        cyc(1);
        wr_valid_i = 1'b0; wr_last_i = 1'b0;
        go();
        chk("scrw_d0", dig(0), C_E);
        chk("scrw_blank", blank_o, 6'h3e);
        halt();

        // overflow: 16 beats without last
        for (int i = 0; i < DEPTH; i++) begin
            c = i[2:0];
            wr_beat(c, 0);
        end
        chk("ovf_ready", wr_ready_o, 1);
        chk("ovf_busy", busy_o, 0);
        go();
        chk("ovf0_d0", dig(0), 3'd0);
        chk("ovf0_busy", busy_o, 1);
        cyc(60);
        chk("ovf15_d0", dig(0), 3'd7);
        chk("ovf15_d5", dig(5), 3'd2);
        chk("ovf15_blank", blank_o, 6'h00);
        cyc(20);
        chk("ovf20_d5", dig(5), 3'd7);
        chk("ovf20_blank", blank_o, 6'h1f);
        chk("ovf20_nodone", done_o, 0);
        cyc(4);
        chk("ovf_done", done_o, 1);
        wr_beat(3'd4, 0); wr_beat(3'd2, 1);
        go();
        chk("new0_d0", dig(0), 3'd4);
        cyc(4);
        chk("new1_d1", dig(1), 3'd4);
        chk("new1_d0", dig(0), 3'd2);

        // mid-pass reset at pos 3
        cyc(8);
        chk("r3_blank", blank_o, 6'h33);
        chk("r3_d3", dig(3), 3'd4);
        #2 rst_ni = 1'b0;
        #1;
        chk("mr_busy", busy_o, 0);
        chk("mr_blank", blank_o, 6'h3f);
        chk("mr_digits", digits_o, 0);
        chk("mr_ready", wr_ready_o, 1);
        chk("mr_done", done_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        go();
        cyc(2);
        chk("mr_start_ign", busy_o, 0);
        chk("mr_blank2", blank_o, 6'h3f);
        wr_beat(C_E, 1);
        go();
        chk("mr_reload_busy", busy_o, 1);
        chk("mr_reload_d0", dig(0), C_E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
